// File: rtl/fetch_pc_unit.sv
// Fetch and PC-sequencing stage: owns the architectural PC, fetches over a req/ack
// port, presents instructions to decode, and drives the PC/LR register-file write ports.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        stall_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    input  logic        instr_ready_i,
    input  logic        branch_valid_i,
    input  logic [31:0] branch_target_i,
    input  logic        branch_link_i,
    output logic [31:0] pc_cur_o,
    output logic        wr_pc_o,
    output logic [31:0] wr_pc_data_o,
    output logic        wr_lr_o,
    output logic [31:0] wr_lr_data_o,
    output logic [1:0]  state_o,
    output logic        flush_pending_o
);

    // Handshakes: imem_req_o/imem_addr_o hold steady until a cycle with imem_ack_i=1;
    // instr_valid_o/instr_o/instr_pc_o hold steady until a cycle with instr_ready_i=1.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        flush_q, flush_d;
    logic [31:0] flush_target_q, flush_target_d;
    logic        flush_link_q, flush_link_d;
    logic        wr_pc_q, wr_pc_d;
    logic [31:0] wr_pc_data_q, wr_pc_data_d;
    logic        wr_lr_q, wr_lr_d;
    logic [31:0] wr_lr_data_q, wr_lr_data_d;

    logic        redir;
    logic [31:0] redir_target;
    logic        redir_link;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q        <= S_FETCH;
            pc_q           <= RESET_PC;
            instr_q        <= '0;
            instr_pc_q     <= '0;
            flush_q        <= 1'b0;
            flush_target_q <= '0;
            flush_link_q   <= 1'b0;
            wr_pc_q        <= 1'b0;
            wr_pc_data_q   <= '0;
            wr_lr_q        <= 1'b0;
            wr_lr_data_q   <= '0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            instr_q        <= instr_d;
            instr_pc_q     <= instr_pc_d;
            flush_q        <= flush_d;
            flush_target_q <= flush_target_d;
            flush_link_q   <= flush_link_d;
            wr_pc_q        <= wr_pc_d;
            wr_pc_data_q   <= wr_pc_data_d;
            wr_lr_q        <= wr_lr_d;
            wr_lr_data_q   <= wr_lr_data_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        instr_d        = instr_q;
        instr_pc_d     = instr_pc_q;
        flush_d        = flush_q;
        flush_target_d = flush_target_q;
        flush_link_d   = flush_link_q;
        wr_pc_d        = 1'b0;
        wr_pc_data_d   = wr_pc_data_q;
        wr_lr_d        = 1'b0;
        wr_lr_data_d   = wr_lr_data_q;
        redir          = 1'b0;
        redir_target   = branch_target_i;
        redir_link     = branch_link_i;

        case (state_q)
            S_IDLE: begin
                if (branch_valid_i) begin
                    redir = 1'b1;
                end else if (!stall_i) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (imem_ack_i) begin
                    if (flush_q || branch_valid_i) begin
                        // A branch arriving with the ack is newer than any pending one.
                        redir = 1'b1;
                        if (!branch_valid_i) begin
                            redir_target = flush_target_q;
                            redir_link   = flush_link_q;
                        end
                        flush_d = 1'b0;
                        state_d = stall_i ? S_IDLE : S_FETCH;
                    end else begin
                        instr_d    = imem_rdata_i;
                        instr_pc_d = pc_q;
                        state_d    = S_HOLD;
                    end
                end else if (branch_valid_i) begin
                    flush_d        = 1'b1;
                    flush_target_d = branch_target_i;
                    flush_link_d   = branch_link_i;
                end
            end
            S_HOLD: begin
                if (branch_valid_i) begin
                    redir   = 1'b1;
                    state_d = stall_i ? S_IDLE : S_FETCH;
                end else if (instr_ready_i) begin
                    pc_d         = pc_q + PC_STEP;
                    wr_pc_d      = 1'b1;
                    wr_pc_data_d = pc_q + PC_STEP;
                    state_d      = stall_i ? S_IDLE : S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase

        if (redir) begin
            pc_d         = redir_target;
            wr_pc_d      = 1'b1;
            wr_pc_data_d = redir_target;
            if (redir_link) begin
                wr_lr_d      = 1'b1;
                wr_lr_data_d = instr_pc_q + PC_STEP;
            end
        end
    end

    assign imem_req_o      = (state_q == S_FETCH) && !reset_i;
    assign imem_addr_o     = pc_q;
    assign instr_valid_o   = (state_q == S_HOLD);
    assign instr_o         = instr_q;
    assign instr_pc_o      = instr_pc_q;
    assign pc_cur_o        = pc_q;
    assign wr_pc_o         = wr_pc_q;
    assign wr_pc_data_o    = wr_pc_data_q;
    assign wr_lr_o         = wr_lr_q;
    assign wr_lr_data_o    = wr_lr_data_q;
    assign state_o         = state_q;
    assign flush_pending_o = flush_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed scenarios followed by random traffic,
// compared every cycle against a transaction-level model of the fetch stage.
module tb_fetch_pc_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_STEP  = 32'd4;
    localparam int PH_IDLE  = 0;
    localparam int PH_FETCH = 1;
    localparam int PH_HOLD  = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        branch_valid;
    logic [31:0] branch_target;
    logic        branch_link;
    logic [31:0] pc_cur;
    logic        wr_pc;
    logic [31:0] wr_pc_data;
    logic        wr_lr;
    logic [31:0] wr_lr_data;
    logic [1:0]  state_dbg;
    logic        flush_pending;

    int n_tests = 0;
    int n_fail  = 0;

    // Model of the stage as seen from its ports.
    int          m_phase;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_ipc;
    logic        m_pend;
    logic [31:0] m_pend_tgt;
    logic        m_pend_link;
    logic        exp_wr;
    logic [31:0] exp_wr_data;
    logic        exp_lr;
    logic [31:0] exp_lr_data;

    fetch_pc_unit #(.RESET_PC(RESET_PC), .PC_STEP(PC_STEP)) dut (
        .clk_i(clk), .reset_i(reset), .stall_i(stall),
        .imem_req_o(imem_req), .imem_addr_o(imem_addr),
        .imem_ack_i(imem_ack), .imem_rdata_i(imem_rdata),
        .instr_valid_o(instr_valid), .instr_o(instr), .instr_pc_o(instr_pc),
        .instr_ready_i(instr_ready),
        .branch_valid_i(branch_valid), .branch_target_i(branch_target),
        .branch_link_i(branch_link),
        .pc_cur_o(pc_cur),
        .wr_pc_o(wr_pc), .wr_pc_data_o(wr_pc_data),
        .wr_lr_o(wr_lr), .wr_lr_data_o(wr_lr_data),
        .state_o(state_dbg), .flush_pending_o(flush_pending)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return addr ^ 32'hC0DE_0000;
    endfunction

    task automatic model_reset();
        m_phase = PH_FETCH; m_pc = RESET_PC; m_instr = '0; m_ipc = '0;
        m_pend = 1'b0; m_pend_tgt = '0; m_pend_link = 1'b0;
        exp_wr = 1'b0; exp_wr_data = '0; exp_lr = 1'b0; exp_lr_data = '0;
    endtask

    task automatic model_redirect(input logic [31:0] tgt, input logic lk);
        m_pc = tgt;
        exp_wr = 1'b1; exp_wr_data = tgt;
        if (lk) begin
            exp_lr = 1'b1; exp_lr_data = m_ipc + PC_STEP;
        end
    endtask

    // One clock of the architectural rules, given the inputs presented in that cycle.
    task automatic model_cycle(input logic st, input logic ack, input logic [31:0] rd,
                               input logic rdy, input logic br, input logic [31:0] tgt,
                               input logic lk);
        exp_wr = 1'b0; exp_lr = 1'b0;
        if (m_phase == PH_IDLE) begin
            if (br) model_redirect(tgt, lk);
            else if (!st) m_phase = PH_FETCH;
        end else if (m_phase == PH_FETCH) begin
            if (ack && (br || m_pend)) begin
                if (br) model_redirect(tgt, lk);
                else    model_redirect(m_pend_tgt, m_pend_link);
                m_pend  = 1'b0;
                m_phase = st ? PH_IDLE : PH_FETCH;
            end else if (ack) begin
                m_instr = rd; m_ipc = m_pc; m_phase = PH_HOLD;
            end else if (br) begin
                m_pend = 1'b1; m_pend_tgt = tgt; m_pend_link = lk;
            end
        end else begin
            if (br) begin
                model_redirect(tgt, lk);
                m_phase = st ? PH_IDLE : PH_FETCH;
            end else if (rdy) begin
                m_pc = m_pc + PC_STEP;
                exp_wr = 1'b1; exp_wr_data = m_pc;
                m_phase = st ? PH_IDLE : PH_FETCH;
            end
        end
    endtask

    task automatic check_outputs();
        check_eq("imem_req", {31'b0, imem_req}, {31'b0, m_phase == PH_FETCH});
        if (m_phase == PH_FETCH) check_eq("imem_addr", imem_addr, m_pc);
        check_eq("pc_cur", pc_cur, m_pc);
        check_eq("instr_valid", {31'b0, instr_valid}, {31'b0, m_phase == PH_HOLD});
        if (m_phase == PH_HOLD) begin
            check_eq("instr", instr, m_instr);
            check_eq("instr_pc", instr_pc, m_ipc);
        end
        check_eq("flush_pending", {31'b0, flush_pending}, {31'b0, m_pend});
        check_eq("wr_pc", {31'b0, wr_pc}, {31'b0, exp_wr});
        if (exp_wr) check_eq("wr_pc_data", wr_pc_data, exp_wr_data);
        check_eq("wr_lr", {31'b0, wr_lr}, {31'b0, exp_lr});
        if (exp_lr) check_eq("wr_lr_data", wr_lr_data, exp_lr_data);
    endtask

    task automatic step(input logic st, input logic ack, input logic [31:0] rd,
                        input logic rdy, input logic br, input logic [31:0] tgt,
                        input logic lk);
        stall = st; imem_ack = ack; imem_rdata = rd; instr_ready = rdy;
        branch_valid = br; branch_target = tgt; branch_link = lk;
        @(posedge clk); #1;
        model_cycle(st, ack, rd, rdy, br, tgt, lk);
        check_outputs();
    endtask

    task automatic ack_fetch();
        step(1'b0, 1'b1, mem_word(m_pc), 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic accept();
        step(1'b0, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_imem_req"}, {31'b0, imem_req}, 32'd0);
        check_eq({tag, "_pc_cur"}, pc_cur, RESET_PC);
        check_eq({tag, "_instr_valid"}, {31'b0, instr_valid}, 32'd0);
        check_eq({tag, "_instr"}, instr, 32'd0);
        check_eq({tag, "_instr_pc"}, instr_pc, 32'd0);
        check_eq({tag, "_wr_pc"}, {31'b0, wr_pc}, 32'd0);
        check_eq({tag, "_wr_pc_data"}, wr_pc_data, 32'd0);
        check_eq({tag, "_wr_lr"}, {31'b0, wr_lr}, 32'd0);
        check_eq({tag, "_wr_lr_data"}, wr_lr_data, 32'd0);
        check_eq({tag, "_flush"}, {31'b0, flush_pending}, 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1; stall = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
        instr_ready = 1'b0; branch_valid = 1'b0; branch_target = '0; branch_link = 1'b0;
        @(posedge clk); #1;
        check_reset_values("rst");
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        do_reset();

        // Sequential fetch of 0, 4, 8 with PC writes of 4, 8, 12.
        for (int i = 0; i < 3; i++) begin
            ack_fetch();
            accept();
        end

        // Decode back-pressure for three cycles, then one accept.
        ack_fetch();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        accept();

        // Branch while fetch at 0x10 is outstanding; ack two cycles later is discarded.
        step(1'b0, 1'b0, '0, 1'b0, 1'b1, 32'h100, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b1, 32'hBAD0_BAD0, 1'b0, 1'b0, '0, 1'b0);
        ack_fetch();

        // Branch-and-link from HOLD at 0x20 racing an accept.
        step(1'b0, 1'b0, '0, 1'b0, 1'b1, 32'h20, 1'b0);
        ack_fetch();
        step(1'b0, 1'b0, '0, 1'b1, 1'b1, 32'h200, 1'b1);
        ack_fetch();

        // PC wrap at the top of the address space, then stall into IDLE.
        step(1'b0, 1'b0, '0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        ack_fetch();
        step(1'b1, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        ack_fetch();
        accept();

        // Reset asserted mid-fetch with an ack about to arrive.
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        imem_ack = 1'b1; imem_rdata = 32'h5555_AAAA;
        #2 reset = 1'b1;
        #1 check_reset_values("midrst");
        imem_ack = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        ack_fetch();
        accept();

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            logic        st, ack, rdy, br, lk;
            logic [31:0] tgt;
            st  = ($urandom_range(0, 3) == 0);
            ack = (m_phase == PH_FETCH) && ($urandom_range(0, 2) != 0);
            rdy = $urandom_range(0, 1) == 1;
            br  = ($urandom_range(0, 7) == 0);
            lk  = $urandom_range(0, 1) == 1;
            tgt = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            step(st, ack, $urandom, rdy, br, tgt, lk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
